// File: rtl/msaa_resolve_seq.sv
// msaa_resolve_seq: streaming MSAA resolve (masked average, masked max or first covered sample)
// over SAMPLES/LANES input beats, with a sequential restoring divider for the average.
module msaa_resolve_seq #(
    parameter int SAMPLES  = 4,
    parameter int LANES    = 2,
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = 10,
    localparam int CNT_W   = $clog2(SAMPLES + 1),
    localparam int SUM_W   = CHAN_W + $clog2(SAMPLES)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*CHANNELS*CHAN_W-1:0]   in_samples,
    input  logic [LANES-1:0]                   in_mask,
    input  logic [1:0]                         mode,
    input  logic [CHANNELS*CHAN_W-1:0]         clear_color,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CHANNELS*CHAN_W-1:0]         out_pixel,
    output logic [CNT_W-1:0]                   out_count,
    output logic                               out_empty
);
    localparam int BEATS  = SAMPLES / LANES;
    localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int STEP_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {ACCUM, DIV, OUT} state_t;
    state_t state, state_nx;

    logic [BEAT_W-1:0] beat;
    logic [1:0] mode_r, mode_eff;
    logic first_beat, last_beat, take_max, take_first, div_done, ge;
    logic [STEP_W-1:0] step;
    logic [CNT_W-1:0] cnt, cnt_nx, divisor;
    logic [CHANNELS-1:0][SUM_W-1:0] sum, sum_nx, quo, quo_nx;
    logic [CHANNELS-1:0][CNT_W-1:0] rem, rem_nx;
    logic [CHANNELS-1:0][CHAN_W-1:0] mx, mx_nx, fst, fst_nx;
    logic [CHAN_W-1:0] smp;
    logic [CNT_W:0] trial;

    always_comb begin
        first_beat = beat == '0;
        last_beat  = beat == BEAT_W'(BEATS - 1);
        mode_eff   = first_beat ? mode : mode_r;
        take_max   = mode_eff == 2'b01;
        take_first = mode_eff == 2'b10;
        div_done   = step == STEP_W'(SUM_W - 1);
        cnt_nx     = (first_beat ? '0 : cnt) + CNT_W'($countones(in_mask));
        smp        = '0;
        trial      = '0;
        ge         = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_nx[c] = first_beat ? '0 : sum[c];
            mx_nx[c]  = first_beat ? '0 : mx[c];
            fst_nx[c] = fst[c];
            // descending scan so the lowest covered lane wins the first-sample slot
            for (int l = LANES - 1; l >= 0; l--) begin
                smp       = in_samples[(l * CHANNELS + c) * CHAN_W +: CHAN_W];
                sum_nx[c] = in_mask[l] ? sum_nx[c] + SUM_W'(smp) : sum_nx[c];
                mx_nx[c]  = in_mask[l] && smp > mx_nx[c] ? smp : mx_nx[c];
                fst_nx[c] = in_mask[l] && (first_beat || cnt == '0) ? smp : fst_nx[c];
            end
            trial     = {rem[c], quo[c][SUM_W-1]};
            ge        = trial >= {1'b0, divisor};
            quo_nx[c] = SUM_W'({quo[c], ge});
            rem_nx[c] = ge ? CNT_W'(trial - {1'b0, divisor}) : CNT_W'(trial);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ACCUM;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (in_valid && last_beat)
                         state_nx = cnt_nx != '0 && !take_max && !take_first ? DIV : OUT;
            DIV:     if (div_done) state_nx = OUT;
            OUT:     if (out_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = state == ACCUM;
        out_valid = state == OUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= '0;
            mode_r    <= '0;
            cnt       <= '0;
            divisor   <= '0;
            step      <= '0;
            sum       <= '0;
            mx        <= '0;
            fst       <= '0;
            quo       <= '0;
            rem       <= '0;
            out_pixel <= '0;
            out_count <= '0;
            out_empty <= 1'b0;
        end else if (state == ACCUM && in_valid) begin
            beat   <= last_beat ? '0 : beat + 1'b1;
            mode_r <= mode_eff;
            cnt    <= cnt_nx;
            sum    <= sum_nx;
            mx     <= mx_nx;
            fst    <= fst_nx;
            if (last_beat) begin
                out_count <= cnt_nx;
                out_empty <= cnt_nx == '0;
                divisor   <= cnt_nx;
                step      <= '0;
                rem       <= '0;
                // dividend carries the half-divisor bias so truncating division rounds to nearest
                for (int c = 0; c < CHANNELS; c++) begin
                    quo[c] <= sum_nx[c] + SUM_W'(cnt_nx >> 1);
                    out_pixel[c*CHAN_W +: CHAN_W] <= cnt_nx == '0 ? clear_color[c*CHAN_W +: CHAN_W] :
                                                     take_max ? mx_nx[c] : fst_nx[c];
                end
            end
        end else if (state == DIV) begin
            step <= step + 1'b1;
            quo  <= quo_nx;
            rem  <= rem_nx;
            if (div_done)
                for (int c = 0; c < CHANNELS; c++)
                    out_pixel[c*CHAN_W +: CHAN_W] <= quo_nx[c][CHAN_W-1:0];
        end
    end
endmodule

// File: tb/tb_msaa_resolve_seq.sv
// tb_msaa_resolve_seq: directed and randomized pixels checked against an arithmetic resolve model,
// with per-cycle protocol, stability and latency checks on the output port.
module tb_msaa_resolve_seq;
    localparam int SAMPLES = 4, LANES = 2, CHANNELS = 4, CHAN_W = 10;
    localparam int BEATS = 2, CNT_W = 3, SUM_W = 12;
    localparam int PW = CHANNELS * CHAN_W;
    localparam int IW = LANES * CHANNELS * CHAN_W;

    typedef struct {
        logic [PW-1:0] pix;
        int cnt;
        int empty;
        int lat;
        int hs_cyc;
    } exp_t;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, out_empty;
    logic [IW-1:0] in_samples = '0;
    logic [LANES-1:0] in_mask = '0;
    logic [1:0] mode = '0;
    logic [PW-1:0] clear_color = '0, out_pixel;
    logic [CNT_W-1:0] out_count;

    int total = 0, bad = 0, cyc = 0;
    exp_t q[$];
    int cur_samp[SAMPLES][CHANNELS];
    logic [SAMPLES-1:0] cur_mask;
    logic [1:0] cur_mode;
    logic [PW-1:0] cur_clear;
    bit gaps = 0, hold_ready = 0;
    logic [PW-1:0] last_pix, prev_pix;
    int last_cnt, last_empty, last_lat;
    bit prev_valid = 0, prev_hs = 0;
    logic [CNT_W-1:0] prev_cnt;
    logic prev_empty;

    msaa_resolve_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_samples(in_samples), .in_mask(in_mask), .mode(mode), .clear_color(clear_color),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_count(out_count), .out_empty(out_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int n = 0;
        for (int s = 0; s < SAMPLES; s++) n += int'(cur_mask[s]);
        e.cnt = n;
        e.empty = n == 0 ? 1 : 0;
        e.lat = (n == 0 || cur_mode == 2'b01 || cur_mode == 2'b10) ? 1 : SUM_W + 1;
        e.hs_cyc = 0;
        e.pix = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            int v = 0, total_c = 0;
            bit found = 0;
            for (int s = 0; s < SAMPLES; s++) begin
                if (!cur_mask[s]) continue;
                total_c += cur_samp[s][c];
                if (cur_samp[s][c] > v && cur_mode == 2'b01) v = cur_samp[s][c];
                if (!found && cur_mode == 2'b10) begin v = cur_samp[s][c]; found = 1; end
            end
            if (n == 0) v = int'(cur_clear[c*CHAN_W +: CHAN_W]);
            else if (cur_mode == 2'b00 || cur_mode == 2'b11) v = (total_c + n / 2) / n;
            e.pix[c*CHAN_W +: CHAN_W] = CHAN_W'(v);
        end
        return e;
    endfunction

    function automatic int rnd_chan();
        int r = $urandom_range(0, 9);
        return r == 0 ? 0 : r == 1 ? 1023 : int'($urandom_range(0, 1023));
    endfunction

    task automatic load(input logic [1:0] md, input logic [SAMPLES-1:0] mk,
                        input int a, input int b, input int c, input int d);
        cur_mode = md;
        cur_mask = mk;
        cur_clear = PW'({$urandom, $urandom});
        for (int s = 0; s < SAMPLES; s++)
            for (int ch = 0; ch < CHANNELS; ch++) cur_samp[s][ch] = rnd_chan();
        cur_samp[0][0] = a;
        cur_samp[1][0] = b;
        cur_samp[2][0] = c;
        cur_samp[3][0] = d;
    endtask

    // entered and left on a falling edge
    task automatic send();
        exp_t e = model();
        for (int b = 0; b < BEATS; b++) begin
            while (gaps && $urandom_range(0, 4) == 0) begin
                in_valid = 0;
                in_samples = IW'({$urandom, $urandom, $urandom});
                in_mask = LANES'($urandom);
                @(negedge clk);
            end
            in_valid = 1;
            in_mask = cur_mask[b*LANES +: LANES];
            for (int l = 0; l < LANES; l++)
                for (int c = 0; c < CHANNELS; c++)
                    in_samples[(l*CHANNELS+c)*CHAN_W +: CHAN_W] = CHAN_W'(cur_samp[b*LANES+l][c]);
            mode = b == 0 ? cur_mode : 2'($urandom);
            clear_color = b == BEATS - 1 ? cur_clear : PW'({$urandom, $urandom});
            for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
            if (!in_ready) check("in_ready timeout", 0, 1);
            if (b == BEATS - 1) begin
                e.hs_cyc = cyc;
                q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            check("drain timeout", q.size(), 0);
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0;
            prev_hs = 0;
        end else begin
            if (prev_hs) check("in_ready after out handshake", int'(in_ready), 1);
            if (out_valid) begin
                check("in_ready while out_valid", int'(in_ready), 0);
                if (!prev_valid) begin
                    if (q.size() == 0) check("unexpected out_valid", 1, 0);
                    else begin
                        last_lat = cyc - q[0].hs_cyc;
                        check("latency", last_lat, q[0].lat);
                    end
                end else begin
                    check("out_pixel stable", int'(out_pixel != prev_pix), 0);
                    check("out_count stable", int'(out_count), int'(prev_cnt));
                    check("out_empty stable", int'(out_empty), int'(prev_empty));
                end
                if (out_ready && q.size() != 0) begin
                    for (int c = 0; c < CHANNELS; c++)
                        check($sformatf("pixel ch%0d", c), int'(out_pixel[c*CHAN_W +: CHAN_W]),
                              int'(q[0].pix[c*CHAN_W +: CHAN_W]));
                    check("count", int'(out_count), q[0].cnt);
                    check("empty", int'(out_empty), q[0].empty);
                    last_pix = out_pixel;
                    last_cnt = int'(out_count);
                    last_empty = int'(out_empty);
                    void'(q.pop_front());
                end
            end
            prev_valid = out_valid && !out_ready;
            prev_hs = out_valid && out_ready;
            prev_pix = out_pixel;
            prev_cnt = out_count;
            prev_empty = out_empty;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_pixel", int'(out_pixel != '0), 0);
        check("reset out_count", int'(out_count), 0);
        check("reset out_empty", int'(out_empty), 0);
        rst = 0;
        @(negedge clk);

        load(2'b00, 4'b1111, 100, 101, 102, 103);
        send(); drain();
        check("t1 avg ch0", int'(last_pix[CHAN_W-1:0]), 102);
        check("t1 count", last_cnt, 4);
        check("t1 latency", last_lat, 13);

        load(2'b00, 4'b0101, 1023, 1023, 0, 1023);
        send(); drain();
        check("t2 avg ch0", int'(last_pix[CHAN_W-1:0]), 512);
        check("t2 count", last_cnt, 2);
        check("t2 empty", last_empty, 0);

        load(2'($urandom), 4'b0000, 1, 2, 3, 4);
        cur_clear = {10'd10, 10'd9, 10'd8, 10'd7};
        send(); drain();
        check("t3 clear pixel", int'(last_pix != {10'd10, 10'd9, 10'd8, 10'd7}), 0);
        check("t3 empty", last_empty, 1);
        check("t3 count", last_cnt, 0);
        check("t3 latency", last_lat, 1);

        load(2'b01, 4'b1110, 5, 900, 7, 3);
        send(); drain();
        check("t4 max ch0", int'(last_pix[CHAN_W-1:0]), 900);
        check("t4 count", last_cnt, 3);
        load(2'b10, 4'b1110, 5, 900, 7, 3);
        send(); drain();
        check("t4 first ch0", int'(last_pix[CHAN_W-1:0]), 900);
        load(2'b00, 4'b1110, 5, 900, 7, 3);
        send(); drain();
        check("t4 avg ch0", int'(last_pix[CHAN_W-1:0]), 303);

        hold_ready = 1;
        load(2'b11, 4'b1011, 10, 20, 30, 40);
        send();
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        check("t5 out_valid rises", int'(out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            check("t5 held out_valid", int'(out_valid), 1);
        end
        hold_ready = 0;
        drain();
        load(2'b00, 4'b1111, 100, 101, 102, 103);
        send(); drain();
        check("t5 next pixel ch0", int'(last_pix[CHAN_W-1:0]), 102);

        load(2'b00, 4'b1111, 500, 600, 700, 800);
        send();
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        check("t6 reset out_valid", int'(out_valid), 0);
        check("t6 reset in_ready", int'(in_ready), 1);
        q.delete();
        @(negedge clk);
        rst = 0;
        load(2'b00, 4'b1111, 100, 101, 102, 103);
        send(); drain();
        check("t6 pixel B ch0", int'(last_pix[CHAN_W-1:0]), 102);

        gaps = 1;
        repeat (300) begin
            int r = $urandom_range(0, 7);
            logic [SAMPLES-1:0] mk = r == 0 ? '0 : r == 1 ? '1 : SAMPLES'($urandom);
            load(2'($urandom), mk, rnd_chan(), rnd_chan(), rnd_chan(), rnd_chan());
            send();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
